// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, the single-outstanding I-cache request and the IF/ID register.
// Define IF_PERF_CNT_EN to add the fetch_count / stall_count performance counters.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0060,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        bubble,
   input  logic        MA_stall,
   output logic        icache_read,
   output logic [31:0] icache_address,
   input  logic [31:0] icache_rdata,
   input  logic        icache_resp,
   output logic [31:0] PC_out,
   output logic [31:0] instr_out,
   output logic        IF_stall
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] fetch_count,
   output logic [31:0] stall_count
`endif
);

   // state   | meaning
   // FETCH   | request at pc_q outstanding
   // HOLD    | fetched word parked in buf_instr, waiting for ID to advance
   // DISCARD | stale request at disc_addr in flight after a redirect; its data is dropped
   typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

   state_t      state;
   logic [31:0] pc_q;
   logic [31:0] buf_instr;
   logic [31:0] disc_addr;
   logic        adv;

   assign adv            = !MA_stall && !bubble;
   assign icache_read    = rst && (state != HOLD);
   assign icache_address = (state == DISCARD) ? disc_addr : pc_q;
   assign IF_stall       = !((state == FETCH && icache_resp) || state == HOLD);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= FETCH;
         pc_q      <= RESET_PC;
         PC_out    <= 32'h0;
         instr_out <= NOP_INSTR;
      end else if (br_taken) begin
         // a redirect flushes IF/ID even when MA_stall freezes the rest of the pipe
         PC_out    <= 32'h0;
         instr_out <= NOP_INSTR;
         pc_q      <= br_target;
         case (state)
            FETCH: begin
               if (!icache_resp) begin
                  disc_addr <= pc_q;
                  state     <= DISCARD;
               end
            end
            HOLD:    state <= FETCH;
            DISCARD: if (icache_resp) state <= FETCH;
            default: state <= FETCH;
         endcase
      end else begin
         case (state)
            FETCH: begin
               if (icache_resp) begin
                  if (adv) begin
                     PC_out    <= pc_q;
                     instr_out <= icache_rdata;
                     pc_q      <= pc_q + 32'd4;
                  end else begin
                     buf_instr <= icache_rdata;
                     state     <= HOLD;
                  end
               end else if (adv) begin
                  PC_out    <= 32'h0;
                  instr_out <= NOP_INSTR;
               end
            end
            HOLD: begin
               if (adv) begin
                  PC_out    <= pc_q;
                  instr_out <= buf_instr;
                  pc_q      <= pc_q + 32'd4;
                  state     <= FETCH;
               end
            end
            DISCARD: begin
               if (adv) begin
                  PC_out    <= 32'h0;
                  instr_out <= NOP_INSTR;
               end
               if (icache_resp) state <= FETCH;
            end
            default: state <= FETCH;
         endcase
      end
   end

`ifdef IF_PERF_CNT_EN
   logic fetch_load;

   assign fetch_load = !br_taken && adv && ((state == FETCH && icache_resp) || state == HOLD);

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_count <= 32'h0;
         stall_count <= 32'h0;
      end else begin
         if (fetch_load) fetch_count <= fetch_count + 32'd1;
         if (IF_stall)   stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch against a flag-based behavioural model and a variable-latency cache.
module tb_instruction_fetch;

   localparam logic [31:0] RESET_PC  = 32'h0000_0060;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        br_taken;
   logic [31:0] br_target;
   logic        bubble;
   logic        MA_stall;
   logic        icache_read;
   logic [31:0] icache_address;
   logic [31:0] icache_rdata;
   logic        icache_resp;
   logic [31:0] PC_out;
   logic [31:0] instr_out;
   logic        IF_stall;
`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_count;
   logic [31:0] stall_count;
`endif

   instruction_fetch #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
      .clk            (clk),
      .rst            (rst),
      .br_taken       (br_taken),
      .br_target      (br_target),
      .bubble         (bubble),
      .MA_stall       (MA_stall),
      .icache_read    (icache_read),
      .icache_address (icache_address),
      .icache_rdata   (icache_rdata),
      .icache_resp    (icache_resp),
      .PC_out         (PC_out),
      .instr_out      (instr_out),
      .IF_stall       (IF_stall)
`ifdef IF_PERF_CNT_EN
      ,
      .fetch_count    (fetch_count),
      .stall_count    (stall_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h60) return 32'h00A0_0093;
      if (a == 32'h64) return 32'h0010_8113;
      return {a[15:0] ^ 16'h5A5A, a[17:2]};
   endfunction

   // model: fetch PC, IF/ID contents, a parked word, and a pending stale request to throw away
   logic [31:0] m_pc, m_if_pc, m_if_instr, m_buf, m_drop_addr;
   logic        m_buf_valid, m_drop;
   logic [31:0] m_fetch_cnt, m_stall_cnt;
   int          c_wait, c_lat, lat_fixed;

   function automatic int pick_lat();
      return (lat_fixed < 0) ? int'($urandom_range(4, 0)) : lat_fixed;
   endfunction

   task automatic model_reset();
      m_pc        = RESET_PC;
      m_if_pc     = 32'h0;
      m_if_instr  = NOP_INSTR;
      m_buf_valid = 1'b0;
      m_drop      = 1'b0;
      m_fetch_cnt = 32'h0;
      m_stall_cnt = 32'h0;
      c_wait      = 0;
      c_lat       = pick_lat();
   endtask

   task automatic step(input logic rst_v, input logic br_v, input logic [31:0] tgt,
                       input logic bub_v, input logic ma_v);
      logic        e_read, e_stall, resp, adv;
      logic [31:0] e_addr, rd;
      @(posedge clk);
      #1;
      chk("PC_out", PC_out, m_if_pc);
      chk("instr_out", instr_out, m_if_instr);
`ifdef IF_PERF_CNT_EN
      chk("fetch_count", fetch_count, m_fetch_cnt);
      chk("stall_count", stall_count, m_stall_cnt);
`endif
      e_read  = rst_v && !m_buf_valid;
      e_addr  = m_drop ? m_drop_addr : m_pc;
      resp    = e_read && (c_wait >= c_lat);
      rd      = mem_word(e_addr);
      e_stall = !(m_buf_valid || (!m_drop && resp));
      rst          = rst_v;
      br_taken     = br_v;
      br_target    = tgt;
      bubble       = bub_v;
      MA_stall     = ma_v;
      icache_resp  = resp;
      icache_rdata = resp ? rd : 32'hDEAD_BEEF;
      #1;
      chk("icache_read", {31'b0, icache_read}, {31'b0, e_read});
      if (e_read) chk("icache_address", icache_address, e_addr);
      chk("IF_stall", {31'b0, IF_stall}, {31'b0, e_stall});

      adv = !ma_v && !bub_v;
      if (!rst_v) begin
         model_reset();
      end else begin
         if (e_stall) m_stall_cnt++;
         if (br_v) begin
            m_if_pc = 32'h0; m_if_instr = NOP_INSTR;
            if (m_drop)           m_drop = !resp;
            else if (m_buf_valid) m_buf_valid = 1'b0;
            else if (!resp) begin m_drop = 1'b1; m_drop_addr = m_pc; end
            m_pc = tgt;
         end else if (m_buf_valid) begin
            if (adv) begin
               m_if_pc = m_pc; m_if_instr = m_buf; m_pc += 4;
               m_buf_valid = 1'b0; m_fetch_cnt++;
            end
         end else if (m_drop) begin
            if (adv) begin m_if_pc = 32'h0; m_if_instr = NOP_INSTR; end
            if (resp) m_drop = 1'b0;
         end else if (resp) begin
            if (adv) begin
               m_if_pc = m_pc; m_if_instr = rd; m_pc += 4; m_fetch_cnt++;
            end else begin
               m_buf = rd; m_buf_valid = 1'b1;
            end
         end else if (adv) begin
            m_if_pc = 32'h0; m_if_instr = NOP_INSTR;
         end
         if (resp) begin c_wait = 0; c_lat = pick_lat(); end
         else if (e_read) c_wait++;
      end
   endtask

   initial begin
      logic [31:0] t;
      rst = 1'b0; br_taken = 1'b0; br_target = 32'h0; bubble = 1'b0; MA_stall = 1'b0;
      icache_resp = 1'b0; icache_rdata = 32'h0;
      lat_fixed = 0;
      model_reset();
      repeat (2) @(posedge clk);

      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("reset_read", {31'b0, icache_read}, 32'h0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("hit_addr0", icache_address, 32'h60);
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("hit_addr1", icache_address, 32'h64);
      chk("hit_pc0", PC_out, 32'h60);
      chk("hit_instr0", instr_out, 32'h00A0_0093);
      step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
      chk("hit_pc1", PC_out, 32'h64);
      chk("hit_instr1", instr_out, 32'h0010_8113);
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("flush_instr", instr_out, NOP_INSTR);
      chk("redirect_addr", icache_address, 32'hFFFF_FFFC);
      lat_fixed = 4;
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("wrap_addr", icache_address, 32'h0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("miss_stall", {31'b0, IF_stall}, 32'h1);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("midmiss_reset_read", {31'b0, icache_read}, 32'h0);
      lat_fixed = -1;
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("restart_addr", icache_address, RESET_PC);

      for (int i = 0; i < 3000; i++) begin
         t = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
         step(($urandom_range(99, 0) != 0), ($urandom_range(9, 0) == 0), t,
              ($urandom_range(4, 0) == 0), ($urandom_range(4, 0) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
